// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for the MMIO controller: window base, register offsets, status bits.
package mmio_ctrl_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RX      = 8'h04;
  localparam logic [7:0] OFF_TX      = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN  = 8'h0C;
  localparam logic [7:0] OFF_CYC     = 8'h10;
  localparam logic [7:0] OFF_INST    = 8'h14;
  localparam logic [7:0] OFF_CLR     = 8'h18;
  localparam logic [7:0] OFF_CYC_HI  = 8'h1C;
  localparam logic [7:0] OFF_INST_HI = 8'h20;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_OVF   = 2;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:8] == base[31:8];
  endfunction

endpackage

// File: rtl/mmio_ctrl_if.sv
// Core data-port bus into the MMIO window; rdata is registered by the slave.
interface mmio_ctrl_if;
  logic [31:0] req_addr;
  logic        req_re;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [31:0] rdata;

  modport master (output req_addr, req_re, req_we, req_wdata, input rdata);
  modport slave  (input req_addr, req_re, req_we, req_wdata, output rdata);
endinterface

// File: rtl/mmio_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO; push on full is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: window decode, UART RX/TX FIFOs, cycle/instret counters, registered read data.
// Optional MMIO_IRQ_EN adds the irq_en register at 0x0C and a registered irq output.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mmio_ctrl_if.slave       bus,
  input  logic             inst_retire,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             irq
);
  logic [7:0]           off;
  logic                 rd;
  logic                 wr;
  logic                 rx_full, rx_empty, rx_pop;
  logic [7:0]           rx_head;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic                 tx_ovf;
  logic [CNT_WIDTH-1:0] cyc_cnt, inst_cnt;
  logic [63:0]          cyc64, inst64;
  logic [31:0]          status, rd_next;
  logic                 cnt_clr;
  logic                 unused_wdata;

  assign off     = bus.req_addr[7:0];
  assign wr      = bus.req_we && in_window(bus.req_addr, BASE_ADDR);
  // A simultaneous read+write is treated as a write only.
  assign rd      = bus.req_re && !bus.req_we && in_window(bus.req_addr, BASE_ADDR);
  assign rx_pop  = rd && off == OFF_RX;
  assign tx_push = wr && off == OFF_TX;
  assign tx_pop  = tx_valid && tx_ready;
  assign cnt_clr = wr && off == OFF_CLR;
  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  assign cyc64   = 64'(cyc_cnt);
  assign inst64  = 64'(inst_cnt);
  assign unused_wdata = ^bus.req_wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid && rx_ready), .pop(rx_pop), .din(rx_data),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.req_wdata[7:0]),
    .full(tx_full), .empty(tx_empty), .head(tx_data)
  );

  always_comb begin
    status = '0;
    status[ST_TX_READY] = !tx_full;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_TX_OVF]   = tx_ovf;
  end

`ifdef MMIO_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr && off == OFF_IRQ_EN) irq_en <= bus.req_wdata[1:0];
      irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_next = '0;
    if (rd) begin
      case (off)
        OFF_STATUS:  rd_next = status;
        OFF_RX:      rd_next = rx_empty ? 32'h0 : {24'h0, rx_head};
        OFF_CYC:     rd_next = cyc64[31:0];
        OFF_INST:    rd_next = inst64[31:0];
        OFF_CYC_HI:  if (CNT_WIDTH == 64) rd_next = cyc64[63:32];
        OFF_INST_HI: if (CNT_WIDTH == 64) rd_next = inst64[63:32];
`ifdef MMIO_IRQ_EN
        OFF_IRQ_EN:  rd_next = {30'h0, irq_en};
`endif
        default:     rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt   <= '0;
      inst_cnt  <= '0;
      tx_ovf    <= 1'b0;
      bus.rdata <= '0;
    end else begin
      // Clear takes priority over the increment in the same cycle.
      if (cnt_clr) begin
        cyc_cnt  <= '0;
        inst_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (inst_retire) inst_cnt <= inst_cnt + 1'b1;
      end
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (rd && off == OFF_STATUS)  tx_ovf <= 1'b0;
      bus.rdata <= rd_next;
    end
  end
endmodule
